// File: rtl/microwave_timer_if.sv
// microwave_timer_if: keypad, magnetron-controller and display signals of the cooking timer
interface microwave_timer_if;
  logic       clearn;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       mag_on;
  logic       timer_done;
  logic       running;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       beep;
  modport master (output clearn, key_valid, key_digit, mag_on,
                  input timer_done, running, min_tens, min_ones, sec_tens, sec_ones, beep);
  modport slave (input clearn, key_valid, key_digit, mag_on,
                 output timer_done, running, min_tens, min_ones, sec_tens, sec_ones, beep);
endinterface

// File: rtl/microwave_timer.sv
// microwave_timer: BCD MM:SS cooking timer counting down while mag_on; optional end-of-cook beep via TIMER_BEEP_EN
module microwave_timer #(
  parameter int TICKS_PER_SEC = 100,
  parameter int BEEP_SECS = 3
) (
  input logic clk,
  input logic resetn,
  microwave_timer_if.slave bus
);
  localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  logic [3:0] d3, d2, d1, d0, n3, n2, n1, n0;
  logic [PW-1:0] ps;
  logic done, run, tick, key, b0, b1, b2, last;
  always_comb begin
    done = ~|{d3, d2, d1, d0};
    run = bus.mag_on & ~done;
    tick = run & (ps == PW'(TICKS_PER_SEC - 1));
    key = bus.key_valid & ~bus.mag_on & (bus.key_digit <= 4'd9);
    last = ~|{d3, d2, d1} & (d0 == 4'd1);
    b0 = d0 == 4'd0;
    b1 = b0 & (d1 == 4'd0);
    b2 = b1 & (d2 == 4'd0);
    n0 = b0 ? 4'd9 : d0 - 4'd1;
    n1 = b0 ? (d1 == 4'd0 ? 4'd5 : d1 - 4'd1) : d1;
    n2 = b1 ? (d2 == 4'd0 ? 4'd9 : d2 - 4'd1) : d2;
    n3 = b2 ? d3 - 4'd1 : d3;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      {d3, d2, d1, d0} <= '0;
      ps <= '0;
    end else if (!bus.clearn) begin
      {d3, d2, d1, d0} <= '0;
      ps <= '0;
    end else if (key) begin
      {d3, d2, d1, d0} <= {d2, d1, d0, bus.key_digit};
    end else if (tick) begin
      {d3, d2, d1, d0} <= {n3, n2, n1, n0};
      ps <= '0;
    end else if (run) begin
      ps <= ps + PW'(1);
    end
  assign bus.timer_done = done;
  assign bus.running = run;
  assign {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones} = {d3, d2, d1, d0};
`ifdef TIMER_BEEP_EN
  localparam int BN = BEEP_SECS * TICKS_PER_SEC;
  localparam int BW = $clog2(BN + 1);
  logic [BW-1:0] bc;
  logic bp;
  // beep starts only on the countdown step 00:01 -> 00:00
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      bp <= 1'b0;
      bc <= '0;
    end else if (!bus.clearn || key) begin
      bp <= 1'b0;
      bc <= '0;
    end else if (tick && last) begin
      bp <= 1'b1;
      bc <= BW'(BN - 1);
    end else if (bp) begin
      if (bc == '0) bp <= 1'b0;
      else bc <= bc - BW'(1);
    end
  assign bus.beep = bp;
`else
  assign bus.beep = 1'b0;
`endif
endmodule

// File: tb/tb_microwave_timer.sv
// tb_microwave_timer: directed and random stimulus checked against a minutes/seconds arithmetic model
module tb_microwave_timer;
  localparam int T = 4, B = 3;
  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;
  microwave_timer_if bus();
  microwave_timer #(.TICKS_PER_SEC(T), .BEEP_SECS(B)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));
  int total = 0, bad = 0;
  int m = 0, s = 0, ps = 0, left = 0;
  logic mg_r = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] model_digits();
    return 16'(((m / 10) << 12) | ((m % 10) << 8) | ((s / 10) << 4) | (s % 10));
  endfunction
  function automatic logic [15:0] dut_digits();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction
  function automatic logic beep_exp();
`ifdef TIMER_BEEP_EN
    return left > 0;
`else
    return 1'b0;
`endif
  endfunction
  task automatic compare();
    chk("digits", 32'(dut_digits()), 32'(model_digits()));
    chk("timer_done", 32'(bus.timer_done), 32'(m == 0 && s == 0));
    chk("running", 32'(bus.running), 32'(bus.mag_on && (m != 0 || s != 0)));
    chk("beep", 32'(bus.beep), 32'(beep_exp()));
  endtask
  task automatic cyc(input logic cl, input logic kv, input logic [3:0] kd, input logic mg);
    int v;
    bus.clearn = cl;
    bus.key_valid = kv;
    bus.key_digit = kd;
    bus.mag_on = mg;
    @(posedge clk);
    if (!cl) begin
      m = 0; s = 0; ps = 0; left = 0;
    end else if (kv && !mg && kd <= 9) begin
      v = ((m * 100 + s) * 10 + int'(kd)) % 10000;
      m = v / 100; s = v % 100; left = 0;
    end else begin
      if (left > 0) left--;
      if (mg && (m != 0 || s != 0)) begin
        if (ps == T - 1) begin
          ps = 0;
          if (s > 0) s--;
          else begin m--; s = 59; end
          if (m == 0 && s == 0) left = B * T;
        end else ps++;
      end
    end
    #1 compare();
  endtask
  task automatic load(input logic [15:0] bcd);
    cyc(1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 3; i >= 0; i--) cyc(1'b1, 1'b1, bcd[i*4 +: 4], 1'b0);
  endtask
  task automatic run(input int n, input logic mg);
    repeat (n) cyc(1'b1, 1'b0, 4'd0, mg);
  endtask
  initial begin
    bus.clearn = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;
    bus.mag_on = 1'b0;
    #2 compare();
    #10 resetn = 1'b1;
    cyc(1'b1, 1'b1, 4'd1, 1'b0);
    cyc(1'b1, 1'b1, 4'd2, 1'b0);
    cyc(1'b1, 1'b1, 4'd3, 1'b0);
    chk("keys123", 32'(dut_digits()), 32'h0123);
    chk("keys_done", 32'(bus.timer_done), 32'd0);
    cyc(1'b1, 1'b1, 4'd12, 1'b0);
    chk("key_gt9", 32'(dut_digits()), 32'h0123);
    cyc(1'b1, 1'b1, 4'd4, 1'b1);
    chk("key_mag_on", 32'(dut_digits()), 32'h0123);
    load(16'h0100);
    run(4, 1'b1);
    chk("min_borrow", 32'(dut_digits()), 32'h0059);
    run(236, 1'b1);
    chk("one_min_zero", 32'(dut_digits()), 32'h0000);
    chk("one_min_done", 32'(bus.timer_done), 32'd1);
    chk("one_min_run", 32'(bus.running), 32'd0);
    run(6, 1'b1);
    chk("zero_hold", 32'(dut_digits()), 32'h0000);
    load(16'h0090);
    run(4, 1'b1);
    chk("s90_first", 32'(dut_digits()), 32'h0089);
    run(356, 1'b1);
    chk("s90_zero", 32'(dut_digits()), 32'h0000);
    load(16'h0005);
    run(6, 1'b1);
    chk("pause_a", 32'(dut_digits()), 32'h0004);
    run(20, 1'b0);
    chk("pause_hold", 32'(dut_digits()), 32'h0004);
    run(2, 1'b1);
    chk("pause_resume", 32'(dut_digits()), 32'h0003);
    run(3, 1'b1);
    cyc(1'b0, 1'b0, 4'd0, 1'b1);
    chk("clear_vs_tick", 32'(dut_digits()), 32'h0000);
    load(16'h0001);
    run(4, 1'b1);
    chk("beep_start", 32'(bus.beep), 32'(beep_exp()));
    run(11, 1'b1);
`ifdef TIMER_BEEP_EN
    chk("beep_last", 32'(bus.beep), 32'd1);
`else
    chk("beep_off", 32'(bus.beep), 32'd0);
`endif
    run(1, 1'b1);
    chk("beep_end", 32'(bus.beep), 32'd0);
    load(16'h0001);
    run(4, 1'b1);
    run(4, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b0);
    chk("beep_cancel", 32'(bus.beep), 32'd0);
    load(16'h0200);
    run(7, 1'b1);
    #3 resetn = 1'b0;
    #1;
    m = 0; s = 0; ps = 0; left = 0;
    chk("areset_digits", 32'(dut_digits()), 32'h0000);
    chk("areset_done", 32'(bus.timer_done), 32'd1);
    chk("areset_run", 32'(bus.running), 32'd0);
    chk("areset_beep", 32'(bus.beep), 32'd0);
    #2 resetn = 1'b1;
    repeat (3000) begin
      if ($urandom_range(0, 29) == 0) mg_r = ~mg_r;
      cyc($urandom_range(0, 60) != 0, $urandom_range(0, 3) == 0,
          4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 2)), mg_r);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/microwave_timer.md
Name: microwave_timer

Overview:
- Cooking-time keeper: the other end of the magnetron controller's mag_on/timer_done interface.
- Captures MM:SS from the keypad as BCD and counts down one second per prescaled tick while mag_on is high.
- Drives timer_done back to the magnetron controller and supplies BCD digits to the display.

Parameters:
TICKS_PER_SEC, 100, clk cycles per second. Set to the clock frequency in synthesis; small values in simulation.
BEEP_SECS, 3, beep duration in seconds (used only with TIMER_BEEP_EN).

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
clearn  input  1  synchronous active-low clear of time and prescaler
key_valid  input  1  one-cycle strobe: key_digit is valid
key_digit  input  4  keypad digit, BCD 0-9
mag_on  input  1  magnetron enabled (from controller); enables countdown
timer_done  output  1  high when time is 00:00
running  output  1  mag_on high and time nonzero
min_tens  output  4  BCD minutes tens
min_ones  output  4  BCD minutes ones
sec_tens  output  4  BCD seconds tens
sec_ones  output  4  BCD seconds ones
beep  output  1  end-of-cook tone enable

Behaviour:
Reset (resetn low, async):
- All digits 0, prescaler 0, beep 0.
- timer_done 1, running 0.
- Reset mid-count aborts the count immediately.

Digit state and status outputs:
- Four 4-bit BCD registers d3..d0 = min_tens, min_ones, sec_tens, sec_ones.
- timer_done = (all digits == 0), decoded from registers; no extra latency.
- running = mag_on & ~timer_done.

Priority each cycle: clearn low > key entry > countdown.

Clear:
- clearn low: digits := 0 and prescaler := 0 on the next edge.

Key entry (accepted only when key_valid & mag_on==0 & key_digit<=9):
- Shift left: d3:=d2, d2:=d1, d1:=d0, d0:=key_digit. The old d3 is discarded.
- Example: keys 1,2,3 give 01:23.
- Keys while mag_on=1 are ignored.
- Keys with value >9 are ignored.

Prescaler:
- Counts 0..TICKS_PER_SEC-1, advancing only while running.
- Holds its value when mag_on drops (pause keeps the partial second).
- Cleared by clearn.
- tick = running & prescaler==TICKS_PER_SEC-1. The prescaler wraps to 0 on tick.

Countdown on tick (BCD borrow chain):
- d0 != 0: d0 -= 1.
- else d0 := 9, and the borrow goes to d1.
  - d1 != 0: d1 -= 1.
  - else d1 := 5, and the borrow goes to d2.
- Minutes use 9/9 decade borrow.
- Entered d1 may exceed 5 (e.g. 00:90 counts 90 s). It decrements normally and only reloads to 5 on a borrow from 0.
- Counting from 00:01 gives 00:00. timer_done rises in the cycle after the tick edge and running falls with it.
- No tick occurs at 00:00; digits never wrap below zero.

Other boundary cases:
- mag_on high with time 00:00: no counting, prescaler holds.
- clearn low coincident with a tick: clear wins, result 00:00, no decrement.
- key_valid coincident with a tick: impossible, because keys are ignored while mag_on.

Optional Feature:
Macro TIMER_BEEP_EN.
- Defined: beep rises on the edge where the digits transition nonzero -> 00:00 by countdown (not by clear or reset).
  - beep stays high for BEEP_SECS*TICKS_PER_SEC cycles using a dedicated counter.
  - It is cancelled early by clearn low or an accepted key.
- Undefined: beep is tied to 0 and no beep counter is instantiated.

Test Plan:
1. Reset with resetn=0 mid-sim -> all digits 0, timer_done=1, running=0, beep=0 asynchronously.
2. TICKS_PER_SEC=4, mag_on=0, keys 1,2,3 -> digits 0,1,2,3 and timer_done=0. Key 12 (>9) -> unchanged. Key 4 while mag_on=1 -> unchanged.
3. Load 01:00, mag_on=1 -> after 4 cycles 00:59; after 240 cycles total 00:00 with timer_done=1, running=0, and further cycles hold at 00:00.
4. Load 00:90, mag_on=1 -> 00:89 after 4 cycles. 00:10 -> 00:09 -> ... -> 00:00 at 360 cycles total.
5. Load 00:05, mag_on=1 for 6 cycles, then 0 for 20 cycles (digits frozen at 00:04, prescaler held at 2), then 1 -> 00:03 after exactly 2 more cycles. clearn=0 together with a tick -> 00:00, no decrement.
6. With TIMER_BEEP_EN and BEEP_SECS=3, TICKS_PER_SEC=4: count 00:01 to zero -> beep high for 12 cycles. Repeat with clearn pulsed after 5 cycles -> beep drops on the next edge. Build without the macro -> beep constant 0.
